muxn_rr_reg: RTL and testbench

MUXN_RR_REG -- requirements
Module: muxn_rr_reg

---
 rtl/mux_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 58 +++++
 rtl/muxn_rr_reg.sv | 65 ++++++
 tb/tb_muxn_rr_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin N:1 mux.
// Default sizes and arbitration mode encodings.
package mux_pkg;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_CHANNELS = 4;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FIXED = 1'b1
    } mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin / fixed-priority arbiter with rotating pointer.
// Grant is combinational; pointer advances only on accepted round-robin grants.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] req,
    input  logic                mode,
    input  logic                advance,
    output logic [CHANNELS-1:0] grant,
    output logic [SELW-1:0]     grant_idx
);

    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_sel;
    logic            w_found;
    int              w_c;

    // Search upward from the pointer (or from 0 in fixed mode) for the first request
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_c       = 0;
        w_sel     = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mode == MODE_FIXED) begin
                w_c = k;
            end else begin
                w_c = (int'(r_ptr) + k) % CHANNELS;
            end
            w_sel = SELW'(w_c);
            if (!w_found && req[w_sel]) begin
                w_found      = 1'b1;
                grant[w_sel] = 1'b1;
                grant_idx    = w_sel;
            end
        end
    end

    // Pointer moves past the winner only when a round-robin grant is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance && mode == MODE_RR) begin
            if (grant_idx == SELW'(CHANNELS - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muxn_rr_reg.sv
// N:1 arbitrated mux feeding a single-entry output register.
// Loads whenever a request exists and the register is empty or draining.
module muxn_rr_reg
    import mux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [CHANNELS-1:0] w_grant;
    logic [SELW-1:0]     w_idx;
    logic                w_load;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_sel;
    logic                r_valid;

    // Reset gating keeps in_ready low while rst_n is held
    assign w_load   = rst_n && (|in_valid) && (!r_valid || out_ready);
    assign in_ready = w_grant & {CHANNELS{w_load}};

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (in_valid),
        .mode      (mode),
        .advance   (w_load),
        .grant     (w_grant),
        .grant_idx (w_idx)
    );

    // Output register: replace on load, empty on drain, otherwise hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
            r_sel   <= w_idx;
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_muxn_rr_reg.sv
// Directed bench for muxn_rr_reg (WIDTH=4, CHANNELS=4).
// Expected values are hand-computed per vector.
module tb_muxn_rr_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [3:0]  out_data;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muxn_rr_reg #(
        .WIDTH    (4),
        .CHANNELS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic out_chk(input string tag, input logic v,
                           input logic [3:0] d, input logic [1:0] s);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data),  32'(d));
        chk({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [3:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        set_data(4'd1, 4'd2, 4'd3, 4'd4);
        #1;
        out_chk("rst0", 1'b0, 4'd0, 2'd0);
        chk("rst0.in_ready", 32'(in_ready), 32'h0);
        step;
        step;
        out_chk("rst1", 1'b0, 4'd0, 2'd0);
        chk("rst1.in_ready", 32'(in_ready), 32'h0);

        // round-robin sweep from ptr=0
        rst_n = 1'b1;
        #1;
        chk("rr.in_ready0", 32'(in_ready), 32'b0001);
        step;
        out_chk("rr0", 1'b1, 4'd1, 2'd0);
        chk("rr.in_ready1", 32'(in_ready), 32'b0010);
        step;
        out_chk("rr1", 1'b1, 4'd2, 2'd1);
        step;
        out_chk("rr2", 1'b1, 4'd3, 2'd2);
        step;
        out_chk("rr3", 1'b1, 4'd4, 2'd3);
        step;
        out_chk("rr4", 1'b1, 4'd1, 2'd0);

        // reset mid-stream
        #2;
        rst_n = 1'b0;
        #1;
        out_chk("mrst", 1'b0, 4'd0, 2'd0);
        chk("mrst.in_ready", 32'(in_ready), 32'h0);
        #1;
        rst_n = 1'b1;
        step;
        out_chk("mrst.first", 1'b1, 4'd1, 2'd0);

        // single request on ch2 (ptr=1)
        in_valid = 4'b0100;
        set_data(4'd0, 4'd0, 4'd9, 4'd0);
        #1;
        chk("single.in_ready", 32'(in_ready), 32'b0100);
        step;
        out_chk("single", 1'b1, 4'd9, 2'd2);

        // ch3 only, wraps ptr back to 0
        in_valid = 4'b1000;
        set_data(4'd0, 4'd0, 4'd0, 4'd7);
        step;
        out_chk("wrap", 1'b1, 4'd7, 2'd3);

        // fixed priority
        mode     = 1'b1;
        in_valid = 4'b1110;
        set_data(4'd1, 4'd2, 4'd3, 4'd4);
        #1;
        chk("fix.in_ready", 32'(in_ready), 32'b0010);
        step;
        out_chk("fix0", 1'b1, 4'd2, 2'd1);
        step;
        out_chk("fix1", 1'b1, 4'd2, 2'd1);
        step;
        out_chk("fix2", 1'b1, 4'd2, 2'd1);

        // back to round-robin with ptr still 0
        mode = 1'b0;
        step;
        out_chk("sw0", 1'b1, 4'd2, 2'd1);
        step;
        out_chk("sw1", 1'b1, 4'd3, 2'd2);
        step;
        out_chk("sw2", 1'b1, 4'd4, 2'd3);

        // backpressure
        in_valid = 4'b0001;
        set_data(4'd5, 4'd6, 4'd0, 4'd0);
        step;
        out_chk("bp.fill", 1'b1, 4'd5, 2'd0);
        out_ready = 1'b0;
        in_valid  = 4'b0011;
        #1;
        chk("bp.in_ready0", 32'(in_ready), 32'h0);
        step;
        out_chk("bp.hold0", 1'b1, 4'd5, 2'd0);
        step;
        out_chk("bp.hold1", 1'b1, 4'd5, 2'd0);
        chk("bp.in_ready1", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        chk("bp.in_ready2", 32'(in_ready), 32'b0010);
        step;
        out_chk("bp.load", 1'b1, 4'd6, 2'd1);

        // drain with no requests
        in_valid = 4'b0000;
        #1;
        chk("drain.in_ready", 32'(in_ready), 32'h0);
        step;
        chk("drain.valid", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
